// File: rtl/sec_carry_resolve.sv
// sec_carry_resolve
//   Absorbs the carry of a Boolean-masked carry-save pair (s, c) into one
//   masked word z, with unmask(z) = unmask(s) + unmask(c) mod 2^K_WIDTH.
//   Each iteration is a DOM AND of s and c (MUL state, cross terms refreshed
//   with rnd and registered), followed by share-local recombination (CMB
//   state). The sum word is s ^ c and the next carry is (s & c) << 1.
//   Shares of different domains only meet inside registered cross terms
//   that are already masked with fresh randomness.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   ena               global enable; low freezes FSM, counter, datapath
//   in_vld / in_rdy   input handshake (in_rdy high only in IDLE)
//   s_in, c_in        sum / carry shares, share i at [i*K_WIDTH +: K_WIDTH]
//   rnd / rnd_req     fresh randomness, consumed on every MUL cycle
//   out_vld / out_rdy output handshake
//   z                 resolved Boolean-masked sum shares
//
// Configuration
//   SEC_CARRY_CLR_EN  when defined, z reads as zero while out_vld is low and
//                     the datapath registers are wiped on DONE -> IDLE.
module sec_carry_resolve #(
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 3,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int RNDW      = K_WIDTH * N_SHARES * (N_SHARES - 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [MASKWIDTH-1:0] s_in,
  input  logic [MASKWIDTH-1:0] c_in,
  input  logic [RNDW-1:0]      rnd,
  output logic                 rnd_req,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [MASKWIDTH-1:0] z
);

  localparam int CNT_W = $clog2(K_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, CMB, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_iter;

  logic [K_WIDTH-1:0] s_in_sh [N_SHARES];
  logic [K_WIDTH-1:0] c_in_sh [N_SHARES];
  logic [K_WIDTH-1:0] r_sh    [N_SHARES][N_SHARES];

  logic [K_WIDTH-1:0] s_q     [N_SHARES];
  logic [K_WIDTH-1:0] c_q     [N_SHARES];
  logic [K_WIDTH-1:0] a_q     [N_SHARES];
  logic [K_WIDTH-1:0] t_q     [N_SHARES][N_SHARES];
  logic [K_WIDTH-1:0] z_q     [N_SHARES];

  logic [K_WIDTH-1:0] g       [N_SHARES];
  logic [K_WIDTH-1:0] c_nxt   [N_SHARES];

  // Share unpacking, randomness distribution (r_ji mirrors r_ij) and output packing.
  for (genvar gi = 0; gi < N_SHARES; gi++) begin : g_share
    assign s_in_sh[gi] = s_in[gi*K_WIDTH +: K_WIDTH];
    assign c_in_sh[gi] = c_in[gi*K_WIDTH +: K_WIDTH];
`ifdef SEC_CARRY_CLR_EN
    assign z[gi*K_WIDTH +: K_WIDTH] = out_vld ? z_q[gi] : '0;
`else
    assign z[gi*K_WIDTH +: K_WIDTH] = z_q[gi];
`endif
    for (genvar gj = 0; gj < N_SHARES; gj++) begin : g_pair
      if (gi < gj) begin : g_upper
        // Lexicographic index of pair (gi, gj) among all i<j pairs.
        localparam int P = gi*N_SHARES - (gi*(gi+1))/2 + (gj - gi - 1);
        assign r_sh[gi][gj] = rnd[P*K_WIDTH +: K_WIDTH];
        assign r_sh[gj][gi] = rnd[P*K_WIDTH +: K_WIDTH];
      end else if (gi == gj) begin : g_diag
        assign r_sh[gi][gj] = '0;
      end
    end
  end

  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_iter = (cnt_inc == CNT_W'(K_WIDTH - 1));

  // Share-local recombination of the registered DOM terms into the next carry.
  always_comb begin
    for (int i = 0; i < N_SHARES; i++) begin
      g[i] = '0;
      for (int j = 0; j < N_SHARES; j++) begin
        g[i] = g[i] ^ t_q[i][j];
      end
      c_nxt[i] = g[i] << 1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_vld) state_nxt = (K_WIDTH == 1) ? DONE : MUL;
      MUL:  state_nxt = CMB;
      CMB:  state_nxt = last_iter ? DONE : MUL;
      DONE: if (out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_rdy  = (state == IDLE);
    rnd_req = (state == MUL);
    out_vld = (state == DONE);
  end

  // Datapath: load -> MUL (masked DOM terms) -> CMB (carry update) -> DONE (z)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < N_SHARES; i++) begin
        s_q[i] <= '0;
        c_q[i] <= '0;
        a_q[i] <= '0;
        z_q[i] <= '0;
        for (int j = 0; j < N_SHARES; j++) begin
          t_q[i][j] <= '0;
        end
      end
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            cnt <= '0;
            for (int i = 0; i < N_SHARES; i++) begin
              s_q[i] <= s_in_sh[i];
              c_q[i] <= c_in_sh[i];
              // A single-bit word has no carry to propagate.
              if (K_WIDTH == 1) z_q[i] <= s_in_sh[i] ^ c_in_sh[i];
            end
          end
        end
        MUL: begin
          for (int i = 0; i < N_SHARES; i++) begin
            a_q[i] <= s_q[i] ^ c_q[i];
            for (int j = 0; j < N_SHARES; j++) begin
              if (i == j) t_q[i][j] <= s_q[i] & c_q[j];
              else        t_q[i][j] <= (s_q[i] & c_q[j]) ^ r_sh[i][j];
            end
          end
        end
        CMB: begin
          cnt <= cnt_inc;
          for (int i = 0; i < N_SHARES; i++) begin
            s_q[i] <= a_q[i];
            c_q[i] <= c_nxt[i];
            // Only the MSB of the carry can remain; its carry-out is dropped.
            if (last_iter) z_q[i] <= a_q[i] ^ c_nxt[i];
          end
        end
        DONE: begin
`ifdef SEC_CARRY_CLR_EN
          if (out_rdy) begin
            for (int i = 0; i < N_SHARES; i++) begin
              s_q[i] <= '0;
              c_q[i] <= '0;
              a_q[i] <= '0;
              for (int j = 0; j < N_SHARES; j++) begin
                t_q[i][j] <= '0;
              end
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_carry_resolve.sv
module tb_sec_carry_resolve;

  localparam int K  = 8;
  localparam int N  = 3;
  localparam int MW = K * N;
  localparam int RW = K * N * (N - 1) / 2;

  logic          clk = 1'b0;
  logic          rst, ena, in_vld, out_rdy;
  logic          in_rdy, rnd_req, out_vld;
  logic [MW-1:0] s_in, c_in, z;
  logic [RW-1:0] rnd;

  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    sb[$];
  bit            rnd_zero;

  sec_carry_resolve #(.K_WIDTH(K), .N_SHARES(N)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .s_in(s_in), .c_in(c_in),
    .rnd(rnd), .rnd_req(rnd_req),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .z(z)
  );

  always #5 clk = ~clk;

  // Fresh randomness every cycle, changed away from the active edge.
  always @(negedge clk) rnd = rnd_zero ? '0 : RW'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] unmask(input logic [MW-1:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic split(input logic [7:0] sv, input logic [7:0] cv, input bit rz);
    logic [7:0] s0, s1, c0, c1;
    s0 = 8'($urandom); s1 = 8'($urandom);
    c0 = 8'($urandom); c1 = 8'($urandom);
    if (rz) begin
      s_in = {8'h00, sv ^ s0, s0};
      c_in = {8'h00, cv ^ c0, c0};
    end else begin
      s_in = {sv ^ s0 ^ s1, s1, s0};
      c_in = {cv ^ c0 ^ c1, c1, c0};
    end
  endtask

  task automatic run_op(input logic [7:0] sv, input logic [7:0] cv, input bit rz,
                        input bit hold, input int gap_at);
    logic [MW-1:0] z0;
    logic [7:0]    exp_v;
    logic          rq;
    int            lat, w, rq_cnt;
    w = 0;
    while (!in_rdy && w < 50) begin tick; w++; end
    if (!in_rdy) begin chk("in_rdy_wait", in_rdy, 1); return; end
    split(sv, cv, rz);
    in_vld = 1'b1;
    tick;
    in_vld = 1'b0;
    sb.push_back(sv + cv);
    lat = 1;
    rq_cnt = 0;
    while (!out_vld && lat < 200) begin
      if (gap_at > 0 && lat == gap_at) begin
        ena = 1'b0;
        rq = rnd_req;
        for (int k = 0; k < 5; k++) begin
          tick;
          lat++;
          chk("rnd_req_frozen", rnd_req, rq);
          chk("out_vld_frozen", out_vld, 0);
        end
        ena = 1'b1;
      end else begin
        if (rnd_req) rq_cnt++;
        tick;
        lat++;
      end
    end
    if (!out_vld) begin
      chk("out_vld_timeout", out_vld, 1);
      sb.delete();
      return;
    end
    chk("latency", lat, 15 + ((gap_at > 0) ? 5 : 0));
    chk("rnd_draws", rq_cnt, K - 1);
    chk("in_rdy_done", in_rdy, 0);
    z0 = z;
    exp_v = sb.pop_front();
    chk("sum", unmask(z), exp_v);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        if (i == 3) begin
          in_vld = 1'b1;
          split(8'hA5, 8'h5A, 1'b0);
        end
        if (i == 4) in_vld = 1'b0;
        tick;
        chk("hold_out_vld", out_vld, 1);
        chk("hold_z", z, z0);
        chk("hold_in_rdy", in_rdy, 0);
      end
      in_vld = 1'b0;
      // A handshake offered while disabled must not complete.
      ena = 1'b0;
      out_rdy = 1'b1;
      tick;
      chk("ena_low_done", out_vld, 1);
      ena = 1'b1;
      out_rdy = 1'b0;
    end
    out_rdy = 1'b1;
    tick;
    out_rdy = 1'b0;
    chk("in_rdy_after", in_rdy, 1);
    chk("out_vld_after", out_vld, 0);
`ifdef SEC_CARRY_CLR_EN
    chk("z_cleared", z, 0);
`else
    chk("z_held", z, z0);
`endif
  endtask

  initial begin
    logic [7:0] a, b;
    rst = 1'b1; ena = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    s_in = '0; c_in = '0; rnd_zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_rnd_req", rnd_req, 0);
    chk("rst_z", z, 0);
    rst = 1'b0;
    tick;

    // Deterministic carry chain with zero randomness.
    run_op(8'h0F, 8'h01, 1'b1, 1'b0, 0);
    rnd_zero = 1'b0;
    // Wrap-around with random masks and randomness.
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    // Back-pressure in DONE, ignored in_vld, disabled handshake.
    run_op(8'h3C, 8'h4D, 1'b0, 1'b1, 0);
    // Enable gap mid-operation.
    run_op(8'h77, 8'h99, 1'b0, 1'b0, $urandom_range(2, 12));

    // Reset in the MUL state of the third iteration.
    split(8'hC3, 8'h3C, 1'b0);
    in_vld = 1'b1;
    tick;
    in_vld = 1'b0;
    sb.push_back(8'hFF);
    repeat (4) tick;
    chk("mid_mul", rnd_req, 1);
    rst = 1'b1;
    #1;
    chk("abort_in_rdy", in_rdy, 1);
    chk("abort_out_vld", out_vld, 0);
    chk("abort_rnd_req", rnd_req, 0);
    chk("abort_z", z, 0);
    tick;
    rst = 1'b0;
    sb.delete();
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(a, b, 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sec_carry_resolve.md
Name: sec_carry_resolve

Overview:
- Consumes the redundant carry-save pair (s, cout) produced by the masked carry-save adder stage of the B2A path.
- Iteratively absorbs the carry into a single Boolean-masked word z, where unmask(z) = unmask(s) + unmask(c) mod 2^K_WIDTH.
- Sits downstream of the CSA tree as its reader.
- Uses an internal first-order-plus DOM AND with one register stage per iteration. Share domains never mix combinationally.

Parameters:
K_WIDTH, 32, bit width of each share
N_SHARES, 3, number of Boolean shares
MASKWIDTH, K_WIDTH*N_SHARES, packed share-vector width
RNDW, K_WIDTH*N_SHARES*(N_SHARES-1)/2, fresh random bits consumed per iteration

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  global enable; low freezes all state, including the FSM, counter and outputs
in_vld  in  1  s_in/c_in valid
in_rdy  out  1  block can accept an input (high only in IDLE)
s_in  in  MASKWIDTH  sum shares; share i at [i*K_WIDTH +: K_WIDTH]
c_in  in  MASKWIDTH  carry shares, same packing
rnd  in  RNDW  fresh randomness, sampled only while rnd_req=1
rnd_req  out  1  high in MUL state; rnd must be fresh every cycle it is high
out_vld  out  1  result valid
out_rdy  in  1  downstream accepts the result
z  out  MASKWIDTH  resolved Boolean-masked sum shares

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE; iteration counter, s_q, c_q, cross-term registers and z are cleared to 0. Reset values: in_rdy=1, out_vld=0, rnd_req=0. Reset mid-operation aborts the computation and discards all partial state.
- All transitions occur only on cycles with ena=1.
- States:
  - IDLE: in_rdy=1. On in_vld=1, load s_q<=s_in and c_q<=c_in, clear the counter. If K_WIDTH=1, go to DONE; otherwise go to MUL.
  - MUL: rnd_req=1. For each share pair i<j, take the K_WIDTH-bit slice r_ij of rnd in lexicographic pair order; r_ji=r_ij.
    - Register cross terms t_ij <= (s_q_i & c_q_j) ^ r_ij for all i!=j.
    - Register inner terms t_ii <= s_q_i & c_q_i.
    - Register a_q <= s_q ^ c_q (share-wise).
    - Go to CMB.
  - CMB: for each share i, g_i = XOR over j of t_ij.
    - c_q_i <= (g_i << 1), truncated to K_WIDTH, LSB filled with 0.
    - s_q <= a_q.
    - Counter increments. If counter reaches K_WIDTH-1, go to DONE; otherwise go to MUL.
  - DONE: z <= s_q ^ c_q (share-wise), registered on entry. out_vld=1 and is held until out_rdy=1, then go to IDLE.
    - This is exact: after K_WIDTH-1 iterations only the MSB of c can be set, and a carry out of the MSB is dropped mod 2^K.
- Latency, from the in_vld accept edge to out_vld high: 2*(K_WIDTH-1)+1 cycles with ena held high. K_WIDTH=1 gives 1 cycle.
- Randomness: exactly K_WIDTH-1 fresh RNDW draws per operation. rnd is never used outside MUL.
- Share-wise invariant: every register holds at most one share domain, or one cross term already masked with r_ij.
- Back-to-back operation: in_rdy rises in the cycle after the out_vld/out_rdy handshake. There is no overlap between operations.
- in_vld in non-IDLE states is ignored and not queued.
- out_rdy while out_vld=0 has no effect.
- ena=0 during DONE: out_vld stays high, and a handshake does not complete.

Optional Feature:
- Macro SEC_CARRY_CLR_EN.
- Defined:
  - z is forced to all-zero whenever out_vld=0.
  - s_q, c_q, a_q and the t_ij registers are cleared on the DONE->IDLE transition.
  - Purpose: removes residual shares from the datapath.
- Undefined:
  - z holds the last result after the handshake.
  - Internal registers keep their stale values until the next load.

Test Plan:
- N_SHARES=3, K_WIDTH=8, rnd=0; unmasked s=0x0F, c=0x01, third shares 0 -> unmask(z)=0x10; out_vld rises 15 cycles after accept.
- N_SHARES=3, K_WIDTH=8, random rnd and random share splits; unmasked s=0xFF, c=0x01 -> unmask(z)=0x00 (wrap-around). Repeat 1000 random vectors against a (s+c) mod 256 model.
- rst asserted for 1 cycle during MUL of iteration 3 -> in_rdy=1, out_vld=0, z=0 immediately. The next operation s=0x12, c=0x34 yields unmask(z)=0x46.
- ena toggled low for 5 random cycles mid-operation -> result unchanged and latency extended by exactly 5. rnd_req stays frozen while ena=0.
- Hold out_rdy=0 for 10 cycles in DONE -> out_vld and z stable, in_rdy=0, and an in_vld pulse is ignored. After out_rdy=1, in_rdy=1 on the next cycle.
- With SEC_CARRY_CLR_EN defined: after the handshake, z=0; count rnd_req-high cycles per operation = 7 for K_WIDTH=8.
